// File: rtl/cpu_jtag_debug_cmd_queue_if.sv
// cpu_jtag_debug_cmd_queue_if: command handshake between the debug queue and the OCI consumer.
interface cpu_jtag_debug_cmd_queue_if #(
  parameter int IR_WIDTH = 2,
  parameter int DR_WIDTH = 38
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] jdo;
  modport master (output cmd_valid, cmd_ir, jdo, input cmd_ready);
  modport slave  (input cmd_valid, cmd_ir, jdo, output cmd_ready);
endinterface

// File: rtl/cpu_jtag_debug_cmd_queue.sv
// cpu_jtag_debug_cmd_queue: synchronises JTAG update strobes and queues captured {ir, dr} commands for the OCI.
module cpu_jtag_debug_cmd_queue #(
  parameter int IR_WIDTH    = 2,
  parameter int DR_WIDTH    = 38,
  parameter int ACTION_BIT  = 35,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  localparam int N_CMD      = 2 ** IR_WIDTH,
  localparam int FW         = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [IR_WIDTH-1:0]           ir_in,
  input  logic [DR_WIDTH-1:0]           sr,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic                          overflow_clr,
  cpu_jtag_debug_cmd_queue_if.master    cmd,
  output logic [N_CMD-1:0]              take_action,
  output logic [N_CMD-1:0]              take_no_action,
  output logic                          ir_update,
  output logic                          overflow,
  output logic [FW-1:0]                 fill
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q, prime_q;
  logic udr_edge_q, uir_edge_q, udr_arm_q, uir_arm_q, overflow_q;
  logic udr_s, uir_s, udr_rise, uir_rise, pop, push, drop;
  logic [IR_WIDTH+DR_WIDTH-1:0] mem_q [DEPTH];
  logic [IR_WIDTH+DR_WIDTH-1:0] head, last_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [FW-1:0] fill_q, fill_d;
  always_comb begin
    udr_s = udr_sync_q[SYNC_STAGES-1];
    uir_s = uir_sync_q[SYNC_STAGES-1];
    udr_rise = ~reset & udr_s & ~udr_edge_q & udr_arm_q;
    uir_rise = ~reset & uir_s & ~uir_edge_q & uir_arm_q;
    pop = ~reset & cmd.cmd_valid & cmd.cmd_ready;
    push = udr_rise & ((fill_q != FULL) | pop);
    drop = udr_rise & ~push;
    fill_d = fill_q + FW'(push) - FW'(pop);
    head = mem_q[rd_q];
  end
  assign cmd.cmd_valid = fill_q != '0;
  assign {cmd.cmd_ir, cmd.jdo} = cmd.cmd_valid ? head : last_q;
  assign take_action = (pop & cmd.jdo[ACTION_BIT]) ? N_CMD'(1) << cmd.cmd_ir : '0;
  assign take_no_action = (pop & ~cmd.jdo[ACTION_BIT]) ? N_CMD'(1) << cmd.cmd_ir : '0;
  assign ir_update = uir_rise;
  assign overflow = overflow_q;
  assign fill = fill_q;
  // Arming waits until prime_q shows the sync chain holds real samples, so a strobe high through reset never arms.
  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      prime_q <= '0;
      udr_edge_q <= 1'b0;
      uir_edge_q <= 1'b0;
      udr_arm_q <= 1'b0;
      uir_arm_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      fill_q <= '0;
      last_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      udr_edge_q <= udr_s;
      uir_edge_q <= uir_s;
      udr_arm_q <= udr_arm_q | (prime_q[SYNC_STAGES-1] & ~udr_s);
      uir_arm_q <= uir_arm_q | (prime_q[SYNC_STAGES-1] & ~uir_s);
      wr_q <= push ? wr_q + 1'b1 : wr_q;
      rd_q <= pop ? rd_q + 1'b1 : rd_q;
      last_q <= pop ? head : last_q;
      fill_q <= fill_d;
      overflow_q <= drop | (overflow_q & ~overflow_clr);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {ir_in, sr};
  end
endmodule

// File: tb/tb_cpu_jtag_debug_cmd_queue.sv
// tb_cpu_jtag_debug_cmd_queue: directed stimulus with a scoreboard monitor checking every popped command.
module tb_cpu_jtag_debug_cmd_queue;
  typedef struct packed {
    logic [1:0]  ir;
    logic [37:0] d;
  } ent_t;
  logic clk, reset, vs_udr, vs_uir, overflow_clr, ir_update, overflow;
  logic [1:0] ir_in;
  logic [37:0] sr;
  logic [3:0] take_action, take_no_action;
  logic [2:0] fill;
  int checks = 0;
  int failures = 0;
  ent_t sb[$];
  cpu_jtag_debug_cmd_queue_if #(.IR_WIDTH(2), .DR_WIDTH(38)) bus ();
  cpu_jtag_debug_cmd_queue dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .overflow_clr(overflow_clr), .cmd(bus), .take_action(take_action),
    .take_no_action(take_no_action), .ir_update(ir_update), .overflow(overflow), .fill(fill)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", n, a, e);
    end
  endtask
  task automatic udr(input logic [1:0] ir, input logic [37:0] d, input bit acc);
    ir_in = ir;
    sr = d;
    if (acc) sb.push_back({ir, d});
    vs_udr = 1'b1;
    tick(3);
    vs_udr = 1'b0;
    tick(3);
  endtask
  initial begin
    logic [37:0] tab [5];
    int cnt;
    tab[0] = 38'h8_0000_00A0;
    tab[1] = 38'h0_0000_00A1;
    tab[2] = 38'h8_0000_00A2;
    tab[3] = 38'h7_FFFF_FFFF;
    tab[4] = 38'h8_0000_00A4;
    reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; overflow_clr = 1'b0;
    ir_in = '0; sr = '0; bus.cmd_ready = 1'b0;
    fork
      begin : monitor
        ent_t e;
        logic [3:0] oh;
        forever begin
          @(negedge clk);
          if (!reset && ((bus.cmd_valid && bus.cmd_ready) || take_action != 0 || take_no_action != 0)) begin
            if (sb.size() == 0) begin
              failures++;
              $display("FAIL unexpected_pop ir=%0d jdo=%h ta=%b tna=%b expected no pop", bus.cmd_ir, bus.jdo, take_action, take_no_action);
            end else begin
              e = sb.pop_front();
              oh = 4'b0001 << e.ir;
              chk("pop_ir", 64'(bus.cmd_ir), 64'(e.ir));
              chk("pop_jdo", 64'(bus.jdo), 64'(e.d));
              chk("pop_take_action", 64'(take_action), 64'(e.d[35] ? oh : 4'b0));
              chk("pop_take_no_action", 64'(take_no_action), 64'(e.d[35] ? 4'b0 : oh));
            end
          end
        end
      end
    join_none
    tick(3);
    reset = 1'b0;
    #1;
    chk("reset_outputs", 64'({bus.cmd_valid, bus.cmd_ir, bus.jdo, take_action, take_no_action, ir_update, overflow, fill}), 64'(0));
    tick(6);
    // 1: latency and take_action on code 2
    bus.cmd_ready = 1'b1;
    ir_in = 2'd2; sr = 38'h8_0000_1234;
    sb.push_back({2'd2, 38'h8_0000_1234});
    vs_udr = 1'b1;
    tick(1);
    chk("t1_valid_k", 64'(bus.cmd_valid), 64'(0));
    tick(1);
    chk("t1_valid_k1", 64'(bus.cmd_valid), 64'(0));
    tick(1);
    chk("t1_valid_k2", 64'(bus.cmd_valid), 64'(1));
    chk("t1_take_action", 64'(take_action), 64'(4'b0100));
    tick(1);
    chk("t1_fill", 64'(fill), 64'(0));
    chk("t1_pulse_gone", 64'({take_action, take_no_action}), 64'(0));
    vs_udr = 1'b0;
    tick(3);
    // 2: overflow on fifth push, pops in order
    bus.cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) udr(2'(i % 4 + i / 4), tab[i], i < 4);
    chk("t2_fill", 64'(fill), 64'(4));
    chk("t2_overflow", 64'(overflow), 64'(1));
    bus.cmd_ready = 1'b1;
    tick(4);
    bus.cmd_ready = 1'b0;
    chk("t2_drained", 64'(fill), 64'(0));
    chk("t2_sb_empty", 64'(sb.size()), 64'(0));
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    chk("t2_overflow_clr", 64'(overflow), 64'(0));
    // 3: full with simultaneous pop and push
    for (int i = 0; i < 4; i++) udr(2'(i), tab[i], 1'b1);
    ir_in = 2'd3; sr = 38'h0_0000_0C33;
    sb.push_back({2'd3, 38'h0_0000_0C33});
    vs_udr = 1'b1;
    tick(2);
    bus.cmd_ready = 1'b1;
    tick(1);
    bus.cmd_ready = 1'b0;
    chk("t3_fill", 64'(fill), 64'(4));
    chk("t3_overflow", 64'(overflow), 64'(0));
    vs_udr = 1'b0;
    tick(3);
    bus.cmd_ready = 1'b1;
    tick(4);
    bus.cmd_ready = 1'b0;
    chk("t3_drained", 64'(fill), 64'(0));
    // 4: take_no_action on code 1, outputs hold last popped value
    udr(2'd1, 38'h0_1234_56AB, 1'b1);
    bus.cmd_ready = 1'b1;
    #1;
    chk("t4_take_no_action", 64'(take_no_action), 64'(4'b0010));
    chk("t4_take_action", 64'(take_action), 64'(0));
    tick(1);
    bus.cmd_ready = 1'b0;
    chk("t4_hold_ir", 64'(bus.cmd_ir), 64'(1));
    chk("t4_hold_jdo", 64'(bus.jdo), 64'(38'h0_1234_56AB));
    // 5: reset mid-operation with vs_udr held high through release
    udr(2'd2, tab[0], 1'b0);
    udr(2'd0, tab[1], 1'b0);
    chk("t5_prefill", 64'(fill), 64'(2));
    vs_udr = 1'b1;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    #1;
    chk("t5_reset_flush", 64'({bus.cmd_valid, fill}), 64'(0));
    tick(8);
    chk("t5_no_push_held", 64'(fill), 64'(0));
    vs_udr = 1'b0;
    tick(4);
    udr(2'd3, tab[2], 1'b1);
    chk("t5_one_push", 64'(fill), 64'(1));
    tick(5);
    chk("t5_still_one", 64'(fill), 64'(1));
    bus.cmd_ready = 1'b1;
    tick(2);
    bus.cmd_ready = 1'b0;
    // 6: set wins over clear; single ir_update
    for (int i = 0; i < 4; i++) udr(2'(3 - i), tab[i + 1], 1'b1);
    udr(2'd0, tab[0], 1'b0);
    chk("t6_overflow_set", 64'(overflow), 64'(1));
    ir_in = 2'd1;
    vs_udr = 1'b1;
    tick(2);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    chk("t6_set_wins", 64'(overflow), 64'(1));
    vs_udr = 1'b0;
    tick(3);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    chk("t6_cleared", 64'(overflow), 64'(0));
    cnt = 0;
    vs_uir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      cnt += int'(ir_update);
    end
    vs_uir = 1'b0;
    chk("t6_ir_update_count", 64'(cnt), 64'(1));
    chk("t6_fill_untouched", 64'(fill), 64'(4));
    bus.cmd_ready = 1'b1;
    tick(5);
    bus.cmd_ready = 1'b0;
    chk("final_fill", 64'(fill), 64'(0));
    chk("final_sb_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
